// File: rtl/regfile_pkg.sv
// Shared register-file definitions: clear-sequencer state encoding, address-width
// helper and the default data width / depth used by decode and writeback.
// No logic; constants and types only.
package regfile_pkg;

  // Clear sequencer states: CLEAR zeroes one entry per cycle, READY serves the core.
  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  localparam int RF_DATA_W = 32;
  localparam int RF_DEPTH  = 32;

  // Address width for a given depth; a depth of 1 still needs a 1-bit index.
  function automatic int rf_addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Clear sequencer: walks every entry writing zero after reset or on clear_req.
// Latency: ready rises exactly DEPTH edges after reset release / clear start.
// Backpressure: none; ready=0 tells the top to drop writes and force reads to 0.
module regfile_clear_ctrl
  import regfile_pkg::*;
#(
  parameter int DEPTH  = RF_DEPTH,
  parameter int ADDR_W = rf_addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_req,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              ready
);

  rf_state_e         state_q, state_nxt;
  logic [ADDR_W-1:0] idx_q, idx_nxt;

  // State register and clear index; reset always restarts the sweep at entry 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RF_CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_nxt;
      idx_q   <= idx_nxt;
    end
  end

  // Next state and clear-write strobe; no array write on an edge where reset is high.
  always_comb begin
    state_nxt = state_q;
    idx_nxt   = idx_q;
    clr_we    = 1'b0;
    clr_addr  = idx_q;
    unique case (state_q)
      RF_CLEAR: begin
        clr_we  = ~reset;
        idx_nxt = idx_q + ADDR_W'(1);
        if (idx_q == ADDR_W'(DEPTH - 1)) begin
          state_nxt = RF_READY;
          idx_nxt   = '0;
        end
      end
      RF_READY: begin
        if (clear_req) begin
          state_nxt = RF_CLEAR;
          idx_nxt   = '0;
        end
      end
      default: begin
        state_nxt = RF_CLEAR;
        idx_nxt   = '0;
      end
    endcase
  end

  assign ready = (state_q == RF_READY);

endmodule

// File: rtl/regfile_multiport.sv
// Multi-read, single-write integer register file with zero-entry, bypass and optional read register.
// Latency: reads combinational (READ_LAT=0) or one cycle (READ_LAT=1); writes land at the edge.
// Backpressure: none; while ready=0 writes are dropped and every read port returns 0.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int DEPTH    = RF_DEPTH,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  parameter bit READ_LAT = 1'b0,
  localparam int ADDR_W  = rf_addr_w(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     clear_req,
  output logic                     ready
);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_hits_zero;
  logic              user_we;
  logic              arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_dat;

  regfile_clear_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_ctrl (
    .clk       (clk),
    .reset     (reset),
    .clear_req (clear_req),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .ready     (ready)
  );

  // User write is accepted only when ready and not pre-empted by a clear or reset.
  always_comb begin
    wr_hits_zero = ZERO_REG && (wr_addr == '0);
    user_we      = ready & wr_en & ~clear_req & ~reset & ~wr_hits_zero;
    arr_we       = clr_we | user_we;
    arr_addr     = clr_we ? clr_addr : wr_addr;
    arr_dat      = clr_we ? '0 : wr_data;
  end

  // Single write port into the array; no reset so it maps onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (arr_we) begin
      mem[arr_addr] <= arr_dat;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rval;

    assign raddr = rd_addr[k*ADDR_W +: ADDR_W];

    // Per-port read value: hardwired zero, then same-cycle bypass, then array contents.
    always_comb begin
      rval = mem[raddr];
      if (ZERO_REG && (raddr == '0)) begin
        rval = '0;
      end else if (BYPASS && wr_en && ready && (wr_addr == raddr)) begin
        rval = wr_data;
      end
      if (!ready) begin
        rval = '0;
      end
    end

    if (READ_LAT) begin : g_reg
      logic [DATA_W-1:0] rval_q;

      // Registered read; rval is already 0 while not ready, so this also holds 0 then.
      always_ff @(posedge clk) begin
        if (reset) begin
          rval_q <= '0;
        end else begin
          rval_q <= rval;
        end
      end

      assign rd_data[k*DATA_W +: DATA_W] = rval_q;
    end else begin : g_comb
      assign rd_data[k*DATA_W +: DATA_W] = rval;
    end
  end

endmodule
